// File: rtl/color_pkg.sv
// Shared types and reset-default configuration for the colour quantiser.
package color_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    TRUNC  = 2'd1,
    ROUND  = 2'd2,
    MIDBIN = 2'd3
  } quant_mode_t;

  localparam quant_mode_t DEF_MODE = BYPASS;

endpackage

// File: rtl/chan_quantize.sv
// Single-channel combinational quantiser: keeps the top k bits of x
// according to the selected mode.
module chan_quantize
  import color_pkg::*;
#(
  parameter int W  = 8,
  parameter int BW = $clog2(W + 1)
) (
  input  logic [W-1:0]  x,
  input  logic [BW-1:0] k,
  input  quant_mode_t   mode,
  output logic [W-1:0]  y
);

  int           d;
  logic [W-1:0] mask;
  logic [W:0]   half;
  logic [W:0]   sum;

  // mask keeps the top k bits; half is 2^(d-1), or 0 when nothing is dropped
  always_comb begin
    d    = W - int'(k);
    mask = {W{1'b1}} << d;
    half = ({{W{1'b0}}, 1'b1} << d) >> 1;
    sum  = {1'b0, x} + half;
    y    = x;
    case (mode)
      BYPASS:  y = x;
      TRUNC:   y = x & mask;
      ROUND:   y = sum[W] ? mask : (sum[W-1:0] & mask);
      MIDBIN:  y = (x & mask) | half[W-1:0];
      default: y = x;
    endcase
  end

endmodule

// File: rtl/color_quantize_stream.sv
// Two-stage pipelined per-channel colour quantiser with shadow/active
// configuration committed on start-of-frame beats.
module color_quantize_stream
  import color_pkg::*;
#(
  parameter int CH       = 3,
  parameter int W        = 8,
  parameter int DEF_BITS = W,
  localparam int CW      = (CH > 1) ? $clog2(CH) : 1,
  localparam int BW      = $clog2(W + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [BW-1:0]   cfg_bits,
  input  logic [1:0]      cfg_mode,
  output logic            cfg_pending,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*W-1:0] in_data,
  input  logic            in_sof,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*W-1:0] out_data,
  output logic            out_sof
);

  localparam int STAGES = 2;

  logic [CH-1:0][BW-1:0] sh_bits_q, sh_bits_d, act_bits_q, act_bits_d;
  logic [CH-1:0][BW-1:0] s1_bits_q, s1_bits_d;
  quant_mode_t           sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  quant_mode_t           s1_mode_q, s1_mode_d;
  logic [CH-1:0][W-1:0]  s1_data_q, s1_data_d, out_data_q, out_data_d, q_data;
  logic                  s1_sof_q, s1_sof_d, out_sof_q, out_sof_d;
  logic [STAGES:1]       vld_pipe_q, vld_pipe_d;
  logic                  en, commit;
  logic [BW-1:0]         wr_bits;

  // Whole pipeline stalls only when the output holds an unaccepted beat
  assign en          = !vld_pipe_q[STAGES] || out_ready;
  assign in_ready    = en;
  assign commit      = in_valid && en && in_sof;
  assign cfg_pending = (sh_bits_q != act_bits_q) || (sh_mode_q != act_mode_q);
  assign out_valid   = vld_pipe_q[STAGES];
  assign out_data    = out_data_q;
  assign out_sof     = out_sof_q;

  // Shadow writes (clamped, out-of-range channel ignored) and sof-triggered commit.
  // The commit copies the pre-write shadow, so a same-cycle write stays pending.
  always_comb begin
    wr_bits   = (int'(cfg_bits) > W) ? BW'(W) : cfg_bits;
    sh_bits_d = sh_bits_q;
    sh_mode_d = sh_mode_q;
    if (cfg_we) begin
      sh_mode_d = quant_mode_t'(cfg_mode);
      for (int c = 0; c < CH; c++)
        if (int'(cfg_ch) == c) sh_bits_d[c] = wr_bits;
    end
    act_bits_d = commit ? sh_bits_q : act_bits_q;
    act_mode_d = commit ? sh_mode_q : act_mode_q;
  end

  // Config register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_bits_q  <= {CH{BW'(DEF_BITS)}};
      act_bits_q <= {CH{BW'(DEF_BITS)}};
      sh_mode_q  <= DEF_MODE;
      act_mode_q <= DEF_MODE;
    end else begin
      sh_bits_q  <= sh_bits_d;
      act_bits_q <= act_bits_d;
      sh_mode_q  <= sh_mode_d;
      act_mode_q <= act_mode_d;
    end
  end

  // Stage advance: S1 captures the beat plus the config it must use
  // (the freshly committed one on a sof beat), S2 captures the result.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_data_d  = s1_data_q;
    s1_sof_d   = s1_sof_q;
    s1_bits_d  = s1_bits_q;
    s1_mode_d  = s1_mode_q;
    out_data_d = out_data_q;
    out_sof_d  = out_sof_q;
    if (en) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
      s1_data_d  = in_data;
      s1_sof_d   = in_sof;
      s1_bits_d  = act_bits_d;
      s1_mode_d  = act_mode_d;
      out_data_d = q_data;
      out_sof_d  = s1_sof_q;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      s1_data_q  <= '0;
      s1_sof_q   <= 1'b0;
      s1_bits_q  <= {CH{BW'(DEF_BITS)}};
      s1_mode_q  <= DEF_MODE;
      out_data_q <= '0;
      out_sof_q  <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_data_q  <= s1_data_d;
      s1_sof_q   <= s1_sof_d;
      s1_bits_q  <= s1_bits_d;
      s1_mode_q  <= s1_mode_d;
      out_data_q <= out_data_d;
      out_sof_q  <= out_sof_d;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    chan_quantize #(.W(W), .BW(BW)) u_q (
      .x    (s1_data_q[c]),
      .k    (s1_bits_q[c]),
      .mode (s1_mode_q),
      .y    (q_data[c])
    );
  end

endmodule

// File: tb/tb_color_quantize_stream.sv
// Directed bench for color_quantize_stream (CH=3, W=8).
module tb_color_quantize_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [3:0]  cfg_bits = '0;
  logic [1:0]  cfg_mode = '0;
  logic        cfg_pending;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic        in_sof = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;
  logic        out_sof;

  int n_vec = 0;
  int n_err = 0;

  color_quantize_stream #(.CH(3), .W(8), .DEF_BITS(8)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_bits(cfg_bits), .cfg_mode(cfg_mode), .cfg_pending(cfg_pending),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sof(out_sof)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int bits, input int mode);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_bits = 4'(bits); cfg_mode = 2'(mode);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_all(input int bits, input int mode);
    for (int c = 0; c < 3; c++) cfg_write(c, bits, mode);
  endtask

  // One beat into an empty pipe; returns what appears two cycles later
  task automatic run_beat(input logic [23:0] d, input logic sof,
                          output logic vld, output logic [23:0] od, output logic osof);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = d; in_sof = sof;
    step();
    in_valid = 1'b0; in_sof = 1'b0;
    step();
    vld = out_valid; od = out_data; osof = out_sof;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_data !== 24'h0 || out_sof !== 1'b0) begin n_err++; $display("FAIL rst_out_data got %h/%b want 000000/0", out_data, out_sof); end
    n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL rst_pending got %b want 0", cfg_pending); end
    in_valid = 1'b1; in_data = 24'h123456; in_sof = 1'b1;
    step();
    in_valid = 1'b0; in_sof = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat1_valid got %b want 0", out_valid); end
    step();
    n_vec++; if (out_valid !== 1'b1 || out_data !== 24'h123456 || out_sof !== 1'b1)
      begin n_err++; $display("FAIL bypass got %b/%h/%b want 1/123456/1", out_valid, out_data, out_sof); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bypass_drain got %b want 0", out_valid); end
  endtask

  task automatic test_trunc();
    logic v, s; logic [23:0] d;
    cfg_all(3, 1);
    n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL trunc_pend got %b want 1", cfg_pending); end
    run_beat(24'hFF7F01, 1'b1, v, d, s);
    n_vec++; if (v !== 1'b1 || d !== 24'hE06000) begin n_err++; $display("FAIL trunc got %b/%h want 1/e06000", v, d); end
    n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL trunc_commit got %b want 0", cfg_pending); end
  endtask

  task automatic test_round();
    logic v, s; logic [23:0] d;
    cfg_all(3, 2);
    run_beat(24'hF57F10, 1'b1, v, d, s);
    n_vec++; if (d !== 24'hE08020) begin n_err++; $display("FAIL round3 got %h want e08020", d); end
    cfg_all(0, 2);
    run_beat(24'h807F80, 1'b1, v, d, s);
    n_vec++; if (d !== 24'h000000) begin n_err++; $display("FAIL round0 got %h want 000000", d); end
    cfg_write(0, 15, 2);
    run_beat(24'h80807B, 1'b1, v, d, s);
    n_vec++; if (d !== 24'h00007B) begin n_err++; $display("FAIL round_clamp got %h want 00007b", d); end
    cfg_write(3, 1, 2);
    n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL bad_ch_pend got %b want 0", cfg_pending); end
  endtask

  task automatic test_midbin();
    logic v, s; logic [23:0] d;
    cfg_write(0, 2, 3); cfg_write(1, 2, 3); cfg_write(2, 8, 3);
    run_beat(24'h5AFF00, 1'b1, v, d, s);
    n_vec++; if (d !== 24'h5AE020) begin n_err++; $display("FAIL midbin got %h want 5ae020", d); end
    cfg_all(0, 3);
    run_beat(24'h12FF00, 1'b1, v, d, s);
    n_vec++; if (d !== 24'h808080) begin n_err++; $display("FAIL midbin0 got %h want 808080", d); end
  endtask

  task automatic test_commit();
    logic v, s; logic [23:0] d;
    cfg_all(4, 1);
    run_beat(24'hABCDEF, 1'b1, v, d, s);
    n_vec++; if (d !== 24'hA0C0E0) begin n_err++; $display("FAIL cm_base got %h want a0c0e0", d); end
    cfg_write(0, 8, 0);
    run_beat(24'hABCDEF, 1'b0, v, d, s);
    n_vec++; if (d !== 24'hA0C0E0 || cfg_pending !== 1'b1)
      begin n_err++; $display("FAIL cm_midframe got %h/%b want a0c0e0/1", d, cfg_pending); end
    // sof beat with a simultaneous shadow write
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 24'hABCDEF; in_sof = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_bits = 4'd2; cfg_mode = 2'd1;
    step();
    cfg_we = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL cm_same_cycle got %b want 1", cfg_pending); end
    step();
    n_vec++; if (out_data !== 24'hABCDEF) begin n_err++; $display("FAIL cm_sof got %h want abcdef", out_data); end
    step();
    run_beat(24'hABCDEF, 1'b0, v, d, s);
    n_vec++; if (d !== 24'hABCDEF) begin n_err++; $display("FAIL cm_after got %h want abcdef", d); end
    run_beat(24'hABCDEF, 1'b1, v, d, s);
    n_vec++; if (d !== 24'hA0C0EF || cfg_pending !== 1'b0)
      begin n_err++; $display("FAIL cm_second got %h/%b want a0c0ef/0", d, cfg_pending); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_q [20];
    int sent, rcvd, cyc;
    logic prev_stall, acc_in, acc_out;
    logic [23:0] prev_data;
    for (int i = 0; i < 20; i++) exp_q[i] = 24'h0A0B00 + 24'(i * 24'h010305);
    cfg_write(0, 8, 0);
    sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    while (rcvd < 20 && cyc < 400) begin
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
      in_data   = (sent < 20) ? exp_q[sent] : 24'h0;
      in_sof    = (sent == 0);
      #1;
      if (prev_stall) begin
        n_vec++;
        if (out_data !== prev_data) begin n_err++; $display("FAIL bp_stable got %h want %h", out_data, prev_data); end
      end
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (acc_out) begin
        n_vec++;
        if (out_data !== exp_q[rcvd] || out_sof !== (rcvd == 0))
          begin n_err++; $display("FAIL bp_beat%0d got %h/%b want %h/%b", rcvd, out_data, out_sof, exp_q[rcvd], rcvd == 0); end
        rcvd++;
      end
      if (acc_in) sent++;
      step();
      cyc++;
    end
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    n_vec++; if (rcvd != 20) begin n_err++; $display("FAIL bp_count got %0d want 20", rcvd); end
    step(); step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_extra got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    logic v, s; logic [23:0] d;
    cfg_all(1, 1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 24'hFFFFFF; in_sof = 1'b1;
    step();
    in_data = 24'h7F7F7F; in_sof = 1'b0;
    step();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mr_fill got %b want 1", out_valid); end
    cfg_write(0, 5, 1);
    n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL mr_pend got %b want 1", cfg_pending); end
    reset = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || cfg_pending !== 1'b0)
      begin n_err++; $display("FAIL mr_clear got %b/%b want 0/0", out_valid, cfg_pending); end
    step();
    reset = 1'b1;
    run_beat(24'h123456, 1'b0, v, d, s);
    n_vec++; if (v !== 1'b1 || d !== 24'h123456) begin n_err++; $display("FAIL mr_default got %b/%h want 1/123456", v, d); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_discard got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_trunc();
    test_round();
    test_midbin();
    test_commit();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
